adc_capture_packer: RTL and testbench

//  ADC-side receive path, the mirror of the DAC byte-duplicating playback path. Takes 256b

---
 rtl/adc_capture_packer_pkg.sv | 34 +++
 rtl/adc_capture_packer.sv | 182 ++++++++++++++++++
 tb/tb_adc_capture_packer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_capture_packer_pkg.sv
// Shared types, constants and byte-lane helpers for the ADC capture packer.
package adc_cap_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cap_state_t;

    localparam int DATA_W         = 256;
    localparam int HALF_W         = 128;
    localparam int BYTES_PER_BEAT = 32;
    localparam int BEAT_SHIFT     = $clog2(BYTES_PER_BEAT);

    // Keep the even byte of every duplicated pair.
    function automatic logic [HALF_W-1:0] decim2(input logic [DATA_W-1:0] din);
        logic [HALF_W-1:0] half;
        half = {HALF_W{1'b0}};
        for (int i = 0; i < HALF_W / 8; i++) begin
            half[8*i +: 8] = din[16*i +: 8];
        end
        return half;
    endfunction

    function automatic logic [HALF_W-1:0] ramp_half(input logic [7:0] base);
        logic [HALF_W-1:0] half;
        half = {HALF_W{1'b0}};
        for (int j = 0; j < HALF_W / 8; j++) begin
            half[8*j +: 8] = base + 8'(j);
        end
        return half;
    endfunction

endpackage

// File: rtl/adc_capture_packer.sv
// ADC receive path: decimate duplicated bytes by 2, pack two halves per beat, frame a capture.
// Optional build macro ADC_CAP_TEST_PATTERN_EN adds a test_mode port selecting a byte ramp.
module adc_capture_packer
    import adc_cap_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              rf_clk,
    input  logic              rf_rst,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
`ifdef ADC_CAP_TEST_PATTERN_EN
    input  logic              test_mode,
`endif
    input  logic              cap_start,
    input  logic              cap_reset,
    input  logic [CNT_W-1:0]  cap_size,
    output logic              cap_busy,
    output logic              cap_done,
    output logic [CNT_W-1:0]  beat_cnt,
    output logic              overflow
);

    localparam logic [CNT_W-1:0] ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ZERO_C = {CNT_W{1'b0}};

    cap_state_t        state_r;
    cap_state_t        state_next_s;
    logic              cap_busy_r;
    logic              cap_done_r;

    logic [HALF_W-1:0] pend_r;
    logic              half_ph_r;
    logic [DATA_W-1:0] out_data_r;
    logic              out_valid_r;
    logic              out_last_r;
    logic [CNT_W-1:0]  beat_cnt_r;
    logic [CNT_W-1:0]  n_beats_r;
    logic              last_loaded_r;
    logic              overflow_r;
`ifdef ADC_CAP_TEST_PATTERN_EN
    logic [7:0]        base_r;
`endif

    logic [CNT_W-1:0]  n_size_s;
    logic              start_s;
    logic              in_acc_s;
    logic              word_done_s;
    logic              hs_s;
    logic              load_s;
    logic              drop_s;
    logic [CNT_W-1:0]  beat_cnt_next_s;
    logic              load_last_s;
    logic [HALF_W-1:0] half_s;
    logic              unused_s;

    assign n_size_s = {{BEAT_SHIFT{1'b0}}, cap_size[CNT_W-1:BEAT_SHIFT]};
    assign unused_s = ^cap_size[BEAT_SHIFT-1:0];

    assign start_s         = cap_start && !cap_reset && (state_r != RUN) && (n_size_s != ZERO_C);
    assign in_acc_s        = (state_r == RUN) && s_axis_tvalid;
    assign word_done_s     = in_acc_s && half_ph_r;
    assign hs_s            = out_valid_r && m_axis_tready;
    assign load_s          = word_done_s && !last_loaded_r && (!out_valid_r || hs_s);
    assign drop_s          = word_done_s && !last_loaded_r && out_valid_r && !hs_s;
    assign beat_cnt_next_s = beat_cnt_r + (hs_s ? ONE_C : ZERO_C);
    // The word being loaded becomes the beat after everything already handed over.
    assign load_last_s     = ((beat_cnt_next_s + ONE_C) == n_beats_r);

    // Select the source of the current decimated half.
    always_comb begin
        half_s = {HALF_W{1'b0}};
`ifdef ADC_CAP_TEST_PATTERN_EN
        half_s = test_mode ? ramp_half(base_r) : decim2(s_axis_tdata);
`else
        half_s = decim2(s_axis_tdata);
`endif
    end

    // Capture FSM next-state logic; abort has priority over everything.
    always_comb begin
        state_next_s = state_r;
        if (cap_reset) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    state_next_s = start_s ? RUN : IDLE;
                RUN:     state_next_s = (hs_s && out_last_r) ? DONE : RUN;
                DONE:    state_next_s = start_s ? RUN : DONE;
                default: state_next_s = IDLE;
            endcase
        end
    end

    // FSM state register and registered status flags.
    always_ff @(posedge rf_clk or posedge rf_rst) begin
        if (rf_rst) begin
            state_r    <= IDLE;
            cap_busy_r <= 1'b0;
            cap_done_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            cap_busy_r <= (state_next_s == RUN);
            cap_done_r <= (state_next_s == DONE);
        end
    end

    // Packer, output register, beat counter and sticky overflow.
    always_ff @(posedge rf_clk or posedge rf_rst) begin
        if (rf_rst) begin
            pend_r        <= {HALF_W{1'b0}};
            half_ph_r     <= 1'b0;
            out_data_r    <= {DATA_W{1'b0}};
            out_valid_r   <= 1'b0;
            out_last_r    <= 1'b0;
            beat_cnt_r    <= ZERO_C;
            n_beats_r     <= ZERO_C;
            last_loaded_r <= 1'b0;
            overflow_r    <= 1'b0;
`ifdef ADC_CAP_TEST_PATTERN_EN
            base_r        <= 8'd0;
`endif
        end else if (cap_reset) begin
            half_ph_r     <= 1'b0;
            out_valid_r   <= 1'b0;
            out_last_r    <= 1'b0;
            beat_cnt_r    <= ZERO_C;
            last_loaded_r <= 1'b0;
        end else if (start_s) begin
            half_ph_r     <= 1'b0;
            out_valid_r   <= 1'b0;
            out_last_r    <= 1'b0;
            beat_cnt_r    <= ZERO_C;
            n_beats_r     <= n_size_s;
            last_loaded_r <= 1'b0;
            overflow_r    <= 1'b0;
`ifdef ADC_CAP_TEST_PATTERN_EN
            base_r        <= 8'd0;
`endif
        end else begin
            if (in_acc_s) begin
                half_ph_r <= !half_ph_r;
                if (!half_ph_r) begin
                    pend_r <= half_s;
                end
`ifdef ADC_CAP_TEST_PATTERN_EN
                base_r <= base_r + 8'd16;
`endif
            end
            beat_cnt_r <= beat_cnt_next_s;
            if (load_s) begin
                out_data_r  <= {half_s, pend_r};
                out_valid_r <= 1'b1;
                out_last_r  <= load_last_s;
                if (load_last_s) begin
                    last_loaded_r <= 1'b1;
                end
            end else if (hs_s) begin
                out_valid_r <= 1'b0;
                out_last_r  <= 1'b0;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign s_axis_tready = 1'b1;
    assign m_axis_tdata  = out_data_r;
    assign m_axis_tvalid = out_valid_r;
    assign m_axis_tlast  = out_last_r;
    assign cap_busy      = cap_busy_r;
    assign cap_done      = cap_done_r;
    assign beat_cnt      = beat_cnt_r;
    assign overflow      = overflow_r;

endmodule

// File: tb/tb_adc_capture_packer.sv
// Randomized and directed bench for adc_capture_packer against a queue-based capture model.
module tb_adc_capture_packer;

    logic         rf_clk = 1'b0;
    logic         rf_rst = 1'b1;
    logic [255:0] s_tdata = '0;
    logic         s_tvalid = 1'b0;
    logic         s_tready;
    logic [255:0] m_tdata;
    logic         m_tvalid;
    logic         m_tready = 1'b1;
    logic         m_tlast;
    logic         test_mode = 1'b0;
    logic         cap_start = 1'b0;
    logic         cap_reset = 1'b0;
    logic [31:0]  cap_size = '0;
    logic         cap_busy;
    logic         cap_done;
    logic [31:0]  beat_cnt;
    logic         overflow;

    adc_capture_packer dut (
        .rf_clk        (rf_clk),
        .rf_rst        (rf_rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
`ifdef ADC_CAP_TEST_PATTERN_EN
        .test_mode     (test_mode),
`endif
        .cap_start     (cap_start),
        .cap_reset     (cap_reset),
        .cap_size      (cap_size),
        .cap_busy      (cap_busy),
        .cap_done      (cap_done),
        .beat_cnt      (beat_cnt),
        .overflow      (overflow)
    );

    always #5 rf_clk = ~rf_clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: capture status, one held output word and a list of collected halves.
    bit            m_run = 0, m_done = 0, m_hv = 0, m_hl = 0, m_ovf = 0;
    logic [255:0]  m_hd = '0;
    int            m_beats = 0, m_n = 0, m_made = 0;
    logic [127:0]  m_halves[$];
    logic [7:0]    m_base = 8'd0;
    logic [255:0]  obs_q[$];

    task automatic model_step();
        bit           hs;
        logic [127:0] half;
        hs = m_hv && m_tready;
        if (cap_reset) begin
            m_run = 0; m_done = 0; m_hv = 0; m_hl = 0; m_beats = 0;
            m_halves.delete();
        end else if (cap_start && !m_run && (cap_size >> 5) != 0) begin
            m_run = 1; m_done = 0; m_hv = 0; m_hl = 0; m_ovf = 0;
            m_n = int'(cap_size >> 5); m_beats = 0; m_made = 0; m_base = 8'd0;
            m_halves.delete();
        end else if (m_run) begin
            if (hs) begin
                m_hv = 0;
                m_beats++;
            end
            if (s_tvalid) begin
                for (int i = 0; i < 16; i++) begin
                    half[8*i +: 8] = s_tdata[16*i +: 8];
`ifdef ADC_CAP_TEST_PATTERN_EN
                    if (test_mode) half[8*i +: 8] = m_base + 8'(i);
`endif
                end
                m_base = m_base + 8'd16;
                m_halves.push_back(half);
                if (m_halves.size() == 2) begin
                    if (m_made < m_n) begin
                        if (!m_hv) begin
                            m_hd = {m_halves[1], m_halves[0]};
                            m_hv = 1;
                            m_made++;
                            m_hl = (m_made == m_n);
                        end else begin
                            m_ovf = 1;
                        end
                    end
                    m_halves.delete();
                end
            end
            if (hs && !m_hv && m_made == m_n) begin
                m_run = 0;
                m_done = 1;
            end
        end
    endtask

    task automatic tick();
        if (m_tvalid && m_tready) obs_q.push_back(m_tdata);
        @(posedge rf_clk);
        model_step();
        #1;
        check_val("busy", 256'(cap_busy), 256'(m_run));
        check_val("done", 256'(cap_done), 256'(m_done));
        check_val("tvalid", 256'(m_tvalid), 256'(m_hv));
        if (m_hv) begin
            check_val("tdata", m_tdata, m_hd);
            check_val("tlast", 256'(m_tlast), 256'(m_hl));
        end
        check_val("beat_cnt", 256'(beat_cnt), 256'(m_beats));
        check_val("overflow", 256'(overflow), 256'(m_ovf));
        check_val("s_tready", 256'(s_tready), 256'(1'b1));
    endtask

    function automatic logic [255:0] dup_ramp();
        logic [255:0] d;
        for (int i = 0; i < 16; i++) d[16*i +: 16] = {8'(i), 8'(i)};
        return d;
    endfunction

    function automatic logic [255:0] rnd_beat();
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    task automatic start_cap(input logic [31:0] size);
        cap_size = size; cap_start = 1'b1;
        tick();
        cap_start = 1'b0;
    endtask

    logic [255:0] exp_w;

    initial begin
        repeat (2) @(posedge rf_clk);
        #1;
        check_val("rst_tvalid", 256'(m_tvalid), 256'(1'b0));
        check_val("rst_tlast", 256'(m_tlast), 256'(1'b0));
        check_val("rst_tdata", m_tdata, 256'd0);
        check_val("rst_beat_cnt", 256'(beat_cnt), 256'd0);
        check_val("rst_overflow", 256'(overflow), 256'(1'b0));
        check_val("rst_busy", 256'(cap_busy), 256'(1'b0));
        rf_rst = 1'b0;
        tick();

        // 1: two beats of the duplicated ramp, no stall
        start_cap(32'd64);
        obs_q.delete();
        s_tdata = dup_ramp();
        s_tvalid = 1'b1;
        repeat (4) tick();
        s_tvalid = 1'b0;
        repeat (3) tick();
        for (int j = 0; j < 32; j++) exp_w[8*j +: 8] = 8'(j % 16);
        check_val("t1_nbeats", 256'(obs_q.size()), 256'd2);
        if (obs_q.size() > 0) check_val("t1_word0", obs_q[0], exp_w);
        check_val("t1_done", 256'(cap_done), 256'(1'b1));
        check_val("t1_cnt", 256'(beat_cnt), 256'd2);

        // 2: paced input, downstream stalling every other cycle
        start_cap(32'd96);
        for (int c = 0; c < 40; c++) begin
            s_tvalid = (c % 4 == 0);
            s_tdata = rnd_beat();
            m_tready = (c % 2 == 1);
            tick();
        end
        s_tvalid = 1'b0; m_tready = 1'b1;
        repeat (3) tick();
        check_val("t2_ovf", 256'(overflow), 256'(1'b0));
        check_val("t2_cnt", 256'(beat_cnt), 256'd3);

        // 3: long stall with continuous input forces drops
        start_cap(32'd128);
        s_tvalid = 1'b1; m_tready = 1'b0;
        for (int c = 0; c < 18; c++) begin
            s_tdata = rnd_beat();
            m_tready = (c >= 6);
            tick();
        end
        s_tvalid = 1'b0; m_tready = 1'b1;
        repeat (3) tick();
        check_val("t3_ovf", 256'(overflow), 256'(1'b1));
        check_val("t3_cnt", 256'(beat_cnt), 256'd4);
        check_val("t3_done", 256'(cap_done), 256'(1'b1));

        // 4: abort after one beat, then a one-beat capture
        start_cap(32'd128);
        s_tvalid = 1'b1;
        repeat (3) begin s_tdata = rnd_beat(); tick(); end
        s_tvalid = 1'b0;
        cap_reset = 1'b1; tick(); cap_reset = 1'b0;
        check_val("t4_busy", 256'(cap_busy), 256'(1'b0));
        check_val("t4_tvalid", 256'(m_tvalid), 256'(1'b0));
        start_cap(32'd32);
        s_tvalid = 1'b1;
        repeat (2) begin s_tdata = rnd_beat(); tick(); end
        s_tvalid = 1'b0;
        repeat (2) tick();
        check_val("t4_done", 256'(cap_done), 256'(1'b1));
        check_val("t4_cnt", 256'(beat_cnt), 256'd1);

        // 5: undersized start ignored; start with abort goes idle
        start_cap(32'd31);
        check_val("t5_nostart", 256'(cap_busy), 256'(1'b0));
        cap_reset = 1'b1; cap_start = 1'b1; cap_size = 32'd64;
        tick();
        cap_reset = 1'b0; cap_start = 1'b0;
        check_val("t5_idle_busy", 256'(cap_busy), 256'(1'b0));
        check_val("t5_idle_done", 256'(cap_done), 256'(1'b0));

`ifdef ADC_CAP_TEST_PATTERN_EN
        // 6: byte ramp replaces ADC data
        test_mode = 1'b1;
        start_cap(32'd320);
        obs_q.delete();
        s_tvalid = 1'b1;
        repeat (20) begin s_tdata = rnd_beat(); tick(); end
        s_tvalid = 1'b0;
        repeat (3) tick();
        check_val("t6_nbeats", 256'(obs_q.size()), 256'd10);
        for (int j = 0; j < 32; j++) exp_w[8*j +: 8] = 8'((32 * 9 + j) % 256);
        if (obs_q.size() == 10) check_val("t6_word9", obs_q[9], exp_w);
        test_mode = 1'b0;
`endif

        // Random captures with random pacing, stalls, aborts and restarts
        for (int r = 0; r < 40; r++) begin
`ifdef ADC_CAP_TEST_PATTERN_EN
            test_mode = 1'($urandom_range(0, 1));
`endif
            start_cap(32'($urandom_range(0, 400)));
            for (int c = 0; c < int'($urandom_range(30, 120)); c++) begin
                s_tvalid  = ($urandom_range(0, 3) != 0);
                s_tdata   = rnd_beat();
                m_tready  = ($urandom_range(0, 2) != 0);
                cap_reset = ($urandom_range(0, 79) == 0);
                cap_start = ($urandom_range(0, 39) == 0);
                if (cap_start) cap_size = 32'($urandom_range(0, 300));
                tick();
            end
            cap_reset = 1'b0; cap_start = 1'b0; s_tvalid = 1'b0; m_tready = 1'b1;
            repeat (3) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
